// File: rtl/q_meter.sv
// Q-tuning measurement engine: settle, excite, then count tank oscillation cycles during envelope ring-down.
// Optional QMETER_SYNC_EN adds 2-flop synchronizers on osc_in, env_hi and env_lo.
module q_meter #(
    parameter int BUS_WIDTH      = 10,
    parameter int SETTLE_CYCLES  = 64,
    parameter int EXCITE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 osc_in,
    input  logic                 env_hi,
    input  logic                 env_lo,
    output logic                 excite,
    output logic                 busy,
    output logic                 ready,
    output logic                 timeout,
    output logic [BUS_WIDTH-1:0] q_measured
);

    localparam int MAX_SE  = (SETTLE_CYCLES > EXCITE_CYCLES) ? SETTLE_CYCLES : EXCITE_CYCLES;
    localparam int MAX_ALL = (MAX_SE > TIMEOUT_CYCLES) ? MAX_SE : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_ALL) + 1;

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] EXCITE_LAST  = TW'(EXCITE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] CNT_MAX = {BUS_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_EXCITE  = 3'd2,
        S_WAIT_HI = 3'd3,
        S_COUNT   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TW-1:0]          r_timer;
    logic [BUS_WIDTH-1:0]   r_cnt;
    logic [BUS_WIDTH-1:0]   r_i_ref_q;
    logic                   r_start_pend;
    logic                   r_osc_d;
    logic                   w_osc_s;
    logic                   w_env_hi_s;
    logic                   w_env_lo_s;
    logic                   w_chg;
    logic                   w_edge;
    logic [BUS_WIDTH-1:0]   w_cnt_inc;
    logic                   w_done;
    logic                   w_done_to;
    logic [BUS_WIDTH-1:0]   w_done_q;

`ifdef QMETER_SYNC_EN
    logic [1:0] r_osc_sync;
    logic [1:0] r_hi_sync;
    logic [1:0] r_lo_sync;

    // Two-stage synchronizers for the analog comparator inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_osc_sync <= 2'b00;
            r_hi_sync  <= 2'b00;
            r_lo_sync  <= 2'b00;
        end else begin
            r_osc_sync <= {r_osc_sync[0], osc_in};
            r_hi_sync  <= {r_hi_sync[0], env_hi};
            r_lo_sync  <= {r_lo_sync[0], env_lo};
        end
    end

    assign w_osc_s    = r_osc_sync[1];
    assign w_env_hi_s = r_hi_sync[1];
    assign w_env_lo_s = r_lo_sync[1];
`else
    assign w_osc_s    = osc_in;
    assign w_env_hi_s = env_hi;
    assign w_env_lo_s = env_lo;
`endif

    assign w_chg     = (i_ref != r_i_ref_q);
    assign w_edge    = w_osc_s & ~r_osc_d;
    assign w_cnt_inc = (w_edge && (r_cnt != CNT_MAX)) ? (r_cnt + BUS_WIDTH'(1)) : r_cnt;

    // Next-state and completion decode; a reference change overrides everything
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_done_to    = 1'b0;
        w_done_q     = w_cnt_inc;
        case (r_state)
            S_IDLE: begin
                if (r_start_pend) w_next_state = S_SETTLE;
                else              w_next_state = S_IDLE;
            end
            S_SETTLE: begin
                if (r_timer == SETTLE_LAST) w_next_state = S_EXCITE;
                else                        w_next_state = S_SETTLE;
            end
            S_EXCITE: begin
                if (r_timer == EXCITE_LAST) w_next_state = S_WAIT_HI;
                else                        w_next_state = S_EXCITE;
            end
            S_WAIT_HI: begin
                if (w_env_hi_s) begin
                    w_next_state = S_COUNT;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                    w_done_to    = 1'b1;
                    w_done_q     = '0;
                end else begin
                    w_next_state = S_WAIT_HI;
                end
            end
            S_COUNT: begin
                if (!w_env_lo_s) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                    w_done_to    = 1'b1;
                end else begin
                    w_next_state = S_COUNT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_chg) begin
            w_next_state = S_SETTLE;
            w_done       = 1'b0;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State, timer, cycle counter and change-detect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_i_ref_q    <= '0;
            r_start_pend <= 1'b1;
            r_osc_d      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_i_ref_q <= i_ref;
            // Tracking osc every cycle means a level already high at COUNT entry is not an edge
            r_osc_d   <= w_osc_s;
            if (w_chg || (w_next_state != r_state)) r_timer <= '0;
            else if (r_state != S_IDLE)            r_timer <= r_timer + TW'(1);
            else                                   r_timer <= r_timer;
            if (w_chg || (r_state != S_COUNT)) r_cnt <= '0;
            else                               r_cnt <= w_cnt_inc;
            if (w_next_state == S_SETTLE) r_start_pend <= 1'b0;
            else                          r_start_pend <= r_start_pend;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excite     <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            timeout    <= 1'b0;
            q_measured <= '0;
        end else begin
            excite <= (w_next_state == S_EXCITE);
            busy   <= (w_next_state != S_IDLE);
            ready  <= w_done;
            if (w_done) begin
                q_measured <= w_done_q;
                timeout    <= w_done_to;
            end else begin
                q_measured <= q_measured;
                timeout    <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_q_meter.sv
// Randomized bench for q_meter: expected counts and latencies come from the measurement rules, not the RTL structure.
module tb_q_meter;

    localparam int BW   = 6;
    localparam int SC   = 8;
    localparam int EC   = 3;
    localparam int TC   = 600;
    localparam int MAXQ = (1 << BW) - 1;
`ifdef QMETER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] i_ref;
    logic          osc_in;
    logic          env_hi;
    logic          env_lo;
    logic          excite;
    logic          busy;
    logic          ready;
    logic          timeout;
    logic [BW-1:0] q_measured;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    q_meter #(
        .BUS_WIDTH     (BW),
        .SETTLE_CYCLES (SC),
        .EXCITE_CYCLES (EC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_ref     (i_ref),
        .osc_in    (osc_in),
        .env_hi    (env_hi),
        .env_lo    (env_lo),
        .excite    (excite),
        .busy      (busy),
        .ready     (ready),
        .timeout   (timeout),
        .q_measured(q_measured)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > MAXQ) ? MAXQ : n;
    endfunction

    task automatic new_ref();
        logic [BW-1:0] r;
        r = i_ref;
        while (r == i_ref) r = BW'($urandom_range(1, MAXQ));
        i_ref = r;
    endtask

    task automatic run_prefix(input bit chg_ref);
        int n;
        bit saw_rdy;
        if (chg_ref) new_ref();
        tick();
        check_eq("busy_start", busy, 1);
        saw_rdy = ready;
        n = 0;
        while (!excite && n < SC + 20) begin
            tick();
            n++;
            saw_rdy |= ready;
        end
        check_eq("settle_len", n, SC);
        n = 0;
        while (excite && n < EC + 20) begin
            tick();
            n++;
            saw_rdy |= ready;
        end
        check_eq("excite_len", n, EC);
        check_eq("no_ready_prefix", saw_rdy, 0);
    endtask

    task automatic drive_edges(input int n, input bit last_with_lo, input int maxw);
        for (int e = 0; e < n; e++) begin
            osc_in = 1'b0;
            repeat ($urandom_range(1, maxw)) tick();
            osc_in = 1'b1;
            if (last_with_lo && e == n - 1) env_lo = 1'b0;
            else repeat ($urandom_range(1, maxw)) tick();
        end
    endtask

    task automatic wait_ready(input int bound, output int t);
        int n;
        n = 0;
        while (!ready && n < bound) begin
            tick();
            n++;
        end
        check_eq("ready_seen", ready, 1);
        t = cyc;
    endtask

    task automatic finish_check(input int exp_q, input bit exp_to);
        check_eq("q_measured", q_measured, exp_q);
        check_eq("timeout", timeout, exp_to);
        tick();
        check_eq("ready_single", ready, 0);
        check_eq("idle_after", busy, 0);
        env_hi = 1'b0;
        env_lo = 1'b1;
        osc_in = 1'b0;
    endtask

    task automatic measure(input int n, input int hi_delay, input bit same_last);
        int t_lo;
        int t;
        bit same;
        same = same_last && (n > 0);
        repeat (hi_delay) tick();
        env_hi = 1'b1;
        drive_edges(n, same, 3);
        if (!same) begin
            osc_in = 1'b0;
            tick();
            env_lo = 1'b0;
        end
        t_lo = cyc;
        wait_ready(40, t);
        check_eq("end_latency", t - t_lo, 1 + LAT);
        finish_check(sat(n), 1'b0);
    endtask

    task automatic count_timeout(input int n, input int maxw);
        int t_hi;
        int t;
        tick();
        env_hi = 1'b1;
        t_hi = cyc;
        drive_edges(n, 1'b0, maxw);
        osc_in = 1'b0;
        wait_ready(TC + 50, t);
        check_eq("count_to_latency", t - t_hi, TC + 1 + LAT);
        finish_check(sat(n), 1'b1);
    endtask

    initial begin
        int t0;
        int t;
        int n;
        rst    = 1'b1;
        i_ref  = BW'($urandom_range(1, MAXQ));
        osc_in = 1'b0;
        env_hi = 1'b0;
        env_lo = 1'b1;
        repeat (3) tick();
        check_eq("rst_q", q_measured, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_excite", excite, 0);
        check_eq("rst_busy", busy, 0);

        // Release, then reset again in the middle of the excite pulse
        rst = 1'b0;
        tick();
        check_eq("busy_after_rst", busy, 1);
        n = 0;
        while (!excite && n < SC + 20) begin
            tick();
            n++;
        end
        check_eq("settle_len0", n, SC);
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_excite", excite, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_q", q_measured, 0);
        tick();
        rst = 1'b0;
        run_prefix(1'b0);
        measure(37, 5, 1'b0);

        // Reference change mid-count aborts, the restart measures fresh
        run_prefix(1'b1);
        repeat (2) tick();
        env_hi = 1'b1;
        drive_edges(12, 1'b0, 3);
        osc_in = 1'b0;
        env_hi = 1'b0;
        run_prefix(1'b1);
        measure(20, 3, 1'b0);

        // env_hi never rises: timeout out of WAIT_HI
        run_prefix(1'b1);
        t0 = cyc;
        wait_ready(TC + 50, t);
        check_eq("wait_hi_latency", t - t0, TC);
        finish_check(0, 1'b1);

        // env_lo never falls: timeout out of COUNT, unsaturated then saturated
        run_prefix(1'b1);
        count_timeout($urandom_range(5, 20), 3);
        run_prefix(1'b1);
        count_timeout(100, 1);

        // Saturation on a normal end
        run_prefix(1'b1);
        measure(70, 2, 1'b0);

        // Reference change in the same cycle env_lo falls
        run_prefix(1'b1);
        tick();
        env_hi = 1'b1;
        drive_edges(8, 1'b0, 2);
        osc_in = 1'b0;
        tick();
        env_lo = 1'b0;
        env_hi = 1'b0;
        run_prefix(1'b1);
        env_lo = 1'b1;
        measure($urandom_range(1, 30), 1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_prefix(1'b1);
            measure($urandom_range(0, 62), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
